// File: rtl/image_capture.sv
// -----------------------------------------------------------------------------
// image_capture
//
// Captures one RGB888 raster frame into an internal pixel buffer. Rows are
// stored bottom-up (BMP order): the first received line goes to the last row
// of the buffer. Malformed line lengths raise a sticky error flag. A
// registered read-back port lets dump/compare logic inspect the buffer.
//
// Optional feature macro: IMAGE_CAPTURE_CHECKSUM_EN
//   defined   -> checksum is a 16-bit wrap-around byte sum of written pixels
//   undefined -> checksum is tied to 0
//
// Parameters:
//   WIDTH   pixels per line
//   HEIGHT  lines per frame
//   ADDR_W  pixel address width, 2**ADDR_W >= WIDTH*HEIGHT
//
// Ports:
//   HCLK, HRESETn        clock (rising edge), async active-low reset
//   VSYNC                frame start; a rising edge arms a new frame
//   HSYNC                pixel valid, high across each line
//   DATA_R/G/B           8-bit colour samples
//   rd_en, rd_addr       buffer read request and pixel index
//   rd_data, rd_valid    read result, one cycle after rd_en
//   frame_done           level, all HEIGHT lines captured
//   line_err             sticky, some line length differed from WIDTH
//   pixel_count          pixels written this frame (saturating)
//   checksum             frame byte sum (0 when feature disabled)
// -----------------------------------------------------------------------------
module image_capture #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R,
  input  logic [7:0]        DATA_G,
  input  logic [7:0]        DATA_B,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data,
  output logic              rd_valid,
  output logic              frame_done,
  output logic              line_err,
  output logic [ADDR_W-1:0] pixel_count,
  output logic [15:0]       checksum
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);

  localparam logic [ADDR_W-1:0] PIX_MAX   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] ROW0_BASE = ADDR_W'(WIDTH * (HEIGHT - 1));
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LINE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              vs_d;
  logic              vs_rise;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;   // buffer index of column 0 of the current row
  logic [ADDR_W-1:0] wr_addr;
  logic              col_full;
  logic              last_row;

  logic              clear;
  logic              wr_en;
  logic              drop;
  logic              line_end;

  logic [23:0]       mem [DEPTH];

  assign vs_rise  = VSYNC & ~vs_d;
  assign col_full = (col == COL_FULL);
  assign last_row = (row == ROW_LAST);
  // Bottom-up row order: row_base walks down by WIDTH per line instead of
  // multiplying WIDTH*(HEIGHT-1-row) every cycle.
  assign wr_addr  = row_base + ADDR_W'(col);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      vs_d  <= 1'b0;
    end else begin
      state <= state_nx;
      vs_d  <= VSYNC;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    wr_en    = 1'b0;
    drop     = 1'b0;
    line_end = 1'b0;

    if (vs_rise) begin
      // A new frame start wins in every state, aborting any frame in flight.
      state_nx = S_ARMED;
      clear    = 1'b1;
    end else begin
      case (state)
        S_IDLE: ;
        S_ARMED, S_GAP: begin
          if (HSYNC) begin
            state_nx = S_LINE;
            wr_en    = 1'b1;
          end
        end
        S_LINE: begin
          if (HSYNC) begin
            if (col_full) drop  = 1'b1;
            else          wr_en = 1'b1;
          end else begin
            line_end = 1'b1;
            state_nx = last_row ? S_DONE : S_GAP;
          end
        end
        S_DONE: ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign frame_done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Position counters and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col         <= '0;
      row         <= '0;
      row_base    <= ROW0_BASE;
      pixel_count <= '0;
      line_err    <= 1'b0;
    end else if (clear) begin
      col         <= '0;
      row         <= '0;
      row_base    <= ROW0_BASE;
      pixel_count <= '0;
      line_err    <= 1'b0;
    end else begin
      if (wr_en) begin
        col <= col + 1'b1;
        if (pixel_count != PIX_MAX) pixel_count <= pixel_count + 1'b1;
      end
      if (drop) line_err <= 1'b1;
      if (line_end) begin
        if (!col_full) line_err <= 1'b1;
        row      <= row + 1'b1;
        row_base <= row_base - WIDTH_A;
        col      <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel buffer: one write port, one registered read port
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; clearing it would prevent RAM inference
  // and its contents are defined only once written.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem[wr_addr] <= {DATA_R, DATA_G, DATA_B};
  end

  // Same-address read during a write returns the pre-write contents.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional frame checksum
  // ---------------------------------------------------------------------------
`ifdef IMAGE_CAPTURE_CHECKSUM_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else if (wr_en) begin
      // Only written pixels count; nothing is written in DONE, so it freezes.
      checksum <= checksum + 16'(DATA_R) + 16'(DATA_G) + 16'(DATA_B);
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_capture.sv
// -----------------------------------------------------------------------------
// tb_image_capture
//
// Directed bench for image_capture at WIDTH=4, HEIGHT=3, ADDR_W=4. Buffer
// read-backs go through a scoreboard queue drained by a monitor on rd_valid;
// status outputs are compared directly after each frame.
// -----------------------------------------------------------------------------
module tb_image_capture;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          VSYNC   = 1'b0;
  logic          HSYNC   = 1'b0;
  logic [7:0]    DATA_R  = '0;
  logic [7:0]    DATA_G  = '0;
  logic [7:0]    DATA_B  = '0;
  logic          rd_en   = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [23:0]   rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic          line_err;
  logic [AW-1:0] pixel_count;
  logic [15:0]   checksum;

  image_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .VSYNC       (VSYNC),
    .HSYNC       (HSYNC),
    .DATA_R      (DATA_R),
    .DATA_G      (DATA_G),
    .DATA_B      (DATA_B),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .pixel_count (pixel_count),
    .checksum    (checksum)
  );

  always #5 HCLK = ~HCLK;

  int n_pass  = 0;
  int n_total = 0;

  logic [23:0] exp_q  [$];
  int          addr_q [$];
  logic [23:0] exp_mem [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Pixel patterns per test; distinct values so stale data is recognisable.
  function automatic logic [23:0] pix(input int pat, input int row, input int col);
    case (pat)
      0:       return {8'(row * 4 + col), 8'h10, 8'h20};
      1:       return {8'(8'h40 + row * 4 + col), 8'h55, 8'h66};
      2:       return {8'(8'h80 + row * 4 + col), 8'h33, 8'h44};
      3:       return {8'(8'hC0 + row * 4 + col), 8'h77, 8'h88};
      4:       return 24'hFFFFFF;
      default: return {8'hEE, 8'(col), 8'h01};
    endcase
  endfunction

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
  endtask

  // Send n pixels of one line followed by a 3-cycle gap; record the pixels
  // that fit in the expected buffer (bottom-up row order).
  task automatic send_line(input int pat, input int row, input int n);
    for (int c = 0; c < n; c++) begin
      {DATA_R, DATA_G, DATA_B} = pix(pat, row, c);
      HSYNC = 1'b1;
      tick();
    end
    HSYNC = 1'b0;
    {DATA_R, DATA_G, DATA_B} = '0;
    repeat (3) tick();
    for (int c = 0; c < n && c < W; c++) exp_mem[W * (H - 1 - row) + c] = pix(pat, row, c);
  endtask

  task automatic read(input int a, input logic [23:0] exp);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    exp_q.push_back(exp);
    addr_q.push_back(a);
    tick();
  endtask

  task automatic end_reads();
    rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) read(a, exp_mem[a]);
    end_reads();
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input int cnt);
    check({tag, " frame_done"}, 32'(frame_done), 32'(done));
    check({tag, " line_err"}, 32'(line_err), 32'(err));
    check({tag, " pixel_count"}, 32'(pixel_count), 32'(cnt));
  endtask

  // Scoreboard monitor: every read response must match the queued expectation.
  always @(negedge HCLK) begin
    if (HRESETn && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_valid unexpected: got data 0x%0h, expected no response", rd_data);
      end else begin
        logic [23:0] e;
        int          a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_sum;

    // ---- power-on reset ----
    repeat (3) tick();
    check("reset rd_data", 32'(rd_data), 0);
    check("reset rd_valid", 32'(rd_valid), 0);
    check_status("reset", 1'b0, 1'b0, 0);
    check("reset checksum", 32'(checksum), 0);
    HRESETn = 1'b1;
    tick();

    // ---- reset asserted mid-line ----
    vsync_pulse();
    for (int c = 0; c < 2; c++) begin
      {DATA_R, DATA_G, DATA_B} = pix(5, 0, c);
      HSYNC = 1'b1;
      tick();
    end
    check("midline pixel_count", 32'(pixel_count), 2);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async rst rd_data", 32'(rd_data), 0);
    check("async rst rd_valid", 32'(rd_valid), 0);
    check_status("async rst", 1'b0, 1'b0, 0);
    check("async rst checksum", 32'(checksum), 0);
    HSYNC = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    // HSYNC without a VSYNC rise must be ignored in IDLE.
    for (int i = 0; i < 3; i++) begin
      HSYNC = 1'b1;
      tick();
      tick();
      HSYNC = 1'b0;
      tick();
    end
    check_status("idle hsync", 1'b0, 1'b0, 0);

    // ---- clean frame ----
    vsync_pulse();
    send_line(0, 0, 4);
    check_status("clean line0", 1'b0, 1'b0, 4);
    send_line(0, 1, 4);
    send_line(0, 2, 4);
    check_status("clean", 1'b1, 1'b0, 12);

    // read latency: rd_valid rises one edge after rd_en, then holds data
    rd_en   = 1'b1;
    rd_addr = AW'(0);
    exp_q.push_back(24'h081020);
    addr_q.push_back(0);
    check("rd_valid before edge", 32'(rd_valid), 0);
    tick();
    check("rd_valid after edge", 32'(rd_valid), 1);
    check("rd_data addr0 direct", 32'(rd_data), 32'h081020);
    rd_en = 1'b0;
    tick();
    check("rd_valid idle", 32'(rd_valid), 0);
    check("rd_data held", 32'(rd_data), 32'h081020);
    read(11, 24'h031020);
    read(12, 24'h000000);
    read(15, 24'h000000);
    end_reads();
    read_all();

    // ---- short line: row 1 has only 3 pixels ----
    vsync_pulse();
    send_line(1, 0, 4);
    send_line(1, 1, 3);
    check_status("short row1", 1'b0, 1'b1, 7);
    send_line(1, 2, 4);
    check_status("short", 1'b1, 1'b1, 11);
    read(7, 24'h071020);
    end_reads();
    read_all();

    // ---- long line: row 0 carries 6 pixels ----
    vsync_pulse();
    send_line(2, 0, 6);
    check_status("long row0", 1'b0, 1'b1, 4);
    send_line(2, 1, 4);
    send_line(2, 2, 4);
    check_status("long", 1'b1, 1'b1, 12);
    read(8, 24'h803344);
    read(11, 24'h833344);
    end_reads();
    read_all();

    // ---- abort after 1.5 lines, then a clean frame without a new VSYNC ----
    vsync_pulse();
    send_line(3, 0, 4);
    for (int c = 0; c < 2; c++) begin
      {DATA_R, DATA_G, DATA_B} = pix(3, 1, c);
      HSYNC = 1'b1;
      tick();
    end
    HSYNC = 1'b0;
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
    check_status("abort rearmed", 1'b0, 1'b0, 0);
    send_line(0, 0, 4);
    send_line(0, 1, 4);
    send_line(0, 2, 4);
    check_status("after abort", 1'b1, 1'b0, 12);
    read_all();

    // ---- all-0xFF frame: checksum ----
    vsync_pulse();
    send_line(4, 0, 4);
    send_line(4, 1, 4);
    send_line(4, 2, 4);
    check_status("ff", 1'b1, 1'b0, 12);
`ifdef IMAGE_CAPTURE_CHECKSUM_EN
    exp_sum = 16'(36 * 255);
`else
    exp_sum = 16'h0000;
`endif
    check("ff checksum", 32'(checksum), 32'(exp_sum));
    read(0, 24'hFFFFFF);
    read(11, 24'hFFFFFF);
    end_reads();

    repeat (3) tick();
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
